// File: rtl/note_to_dds.sv
// note_to_dds: MIDI note number to DDS phase increment.
// The note is split into octave/semitone with a constant comparison chain,
// the semitone selects a top-octave increment from a 12-entry ROM, and the
// entry is shifted down by (10 - octave) into a registered output.
module note_to_dds #(
    parameter int unsigned CLK_HZ = 50000000, // ROM constants are fixed for 50 MHz
    parameter int unsigned OUT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       note,
    output logic [OUT_W-1:0] adder
);

    logic [3:0]       octave;
    logic [6:0]       remainder;
    logic [3:0]       semitone;
    logic [23:0]      rom_val;
    logic [3:0]       shift;
    logic [OUT_W-1:0] next_adder;

    // Octave / semitone split: thresholds at multiples of 12, no divider.
    always_comb begin
        octave    = '0;
        remainder = note;
        if (note >= 7'd120) begin
            octave    = 4'd10;
            remainder = note - 7'd120;
        end else if (note >= 7'd108) begin
            octave    = 4'd9;
            remainder = note - 7'd108;
        end else if (note >= 7'd96) begin
            octave    = 4'd8;
            remainder = note - 7'd96;
        end else if (note >= 7'd84) begin
            octave    = 4'd7;
            remainder = note - 7'd84;
        end else if (note >= 7'd72) begin
            octave    = 4'd6;
            remainder = note - 7'd72;
        end else if (note >= 7'd60) begin
            octave    = 4'd5;
            remainder = note - 7'd60;
        end else if (note >= 7'd48) begin
            octave    = 4'd4;
            remainder = note - 7'd48;
        end else if (note >= 7'd36) begin
            octave    = 4'd3;
            remainder = note - 7'd36;
        end else if (note >= 7'd24) begin
            octave    = 4'd2;
            remainder = note - 7'd24;
        end else if (note >= 7'd12) begin
            octave    = 4'd1;
            remainder = note - 7'd12;
        end
        semitone = remainder[3:0];
    end

    // Top-octave increments (notes 120..131) at 50 MHz; unused codes give 0.
    always_comb begin
        rom_val = '0;
        case (semitone)
            4'd0:    rom_val = 24'd719151;
            4'd1:    rom_val = 24'd761911;
            4'd2:    rom_val = 24'd807213;
            4'd3:    rom_val = 24'd855209;
            4'd4:    rom_val = 24'd906059;
            4'd5:    rom_val = 24'd959932;
            4'd6:    rom_val = 24'd1016999;
            4'd7:    rom_val = 24'd1077509;
            4'd8:    rom_val = 24'd1141575;
            4'd9:    rom_val = 24'd1209463;
            4'd10:   rom_val = 24'd1281381;
            4'd11:   rom_val = 24'd1357571;
            default: rom_val = '0;
        endcase
    end

    // Logical right shift (floor) by the octave distance from the top octave.
    always_comb begin
        shift      = 4'd10 - octave;
        next_adder = OUT_W'(rom_val) >> shift;
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adder <= '0;
        end else begin
            adder <= next_adder;
        end
    end

endmodule

// File: tb/tb_note_to_dds.sv
// Testbench for note_to_dds: scoreboard of expected outputs, one per edge.
module tb_note_to_dds;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  note;
    logic [31:0] adder;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] sweep_out [128];
    logic [23:0] rom_tb [12] = '{24'd719151, 24'd761911, 24'd807213, 24'd855209,
                                 24'd906059, 24'd959932, 24'd1016999, 24'd1077509,
                                 24'd1141575, 24'd1209463, 24'd1281381, 24'd1357571};
    logic [31:0] last_out;

    note_to_dds #(.CLK_HZ(50000000), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .note  (note),
        .adder (adder)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input int n);
        int oct;
        int s;
        oct = n / 12;
        s   = n % 12;
        return {8'd0, rom_tb[s]} >> (10 - oct);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic [6:0] n, input logic r, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        note  = n;
        rst_n = r;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        last_out = adder;
        check(tag, adder, e);
    endtask

    initial begin
        rst_n = 1'b0;
        note  = 7'd69;

        // Reset held for three edges, then released.
        for (int i = 0; i < 3; i++) step(7'd69, 1'b0, 32'd0, "reset_hold");
        step(7'd69, 1'b1, 32'd37795, "reset_release");

        // Reference pitches and boundaries.
        step(7'd69,  1'b1, 32'd37795,   "note69");
        step(7'd117, 1'b1, 32'd604731,  "note117");
        step(7'd57,  1'b1, 32'd18897,   "note57");
        step(7'd0,   1'b1, 32'd702,     "note0");
        step(7'd127, 1'b1, 32'd1077509, "note127");
        step(7'd120, 1'b1, 32'd719151,  "note120");
        step(7'd11,  1'b1, 32'd1325,    "note11");
        step(7'd12,  1'b1, 32'd1404,    "note12");

        // Back-to-back note changes.
        step(7'd0,   1'b1, 32'd702,     "b2b_0");
        step(7'd127, 1'b1, 32'd1077509, "b2b_127");
        step(7'd69,  1'b1, 32'd37795,   "b2b_69");
        step(7'd12,  1'b1, 32'd1404,    "b2b_12");

        // Full sweep against the division-based model.
        for (int n = 0; n < 128; n++) begin
            step(7'(n), 1'b1, model(n), "sweep");
            sweep_out[n] = last_out;
        end
        for (int n = 0; n <= 115; n++)
            check("octave_rel", sweep_out[n + 12] >> 1, sweep_out[n]);
        for (int n = 1; n < 128; n++)
            check("monotonic", 32'(sweep_out[n] >= sweep_out[n - 1]), 32'd1);

        // Reset asserted mid-stream, then recovery.
        step(7'd90,  1'b1, model(90), "pre_reset");
        step(7'd100, 1'b0, 32'd0,     "mid_reset");
        step(7'd100, 1'b1, 32'd226514, "post_reset");

        // Random notes.
        for (int i = 0; i < 40; i++) begin
            int n;
            n = int'($urandom_range(127, 0));
            step(7'(n), 1'b1, model(n), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
